seq_divider_n: RTL and testbench

- Parametrised multi-cycle restoring divider for the ALU datapath. It supersedes the fixed 8-bit unsigned divider.
- Adds run-time signed/unsigned mode, divide-by-zero and signed-overflow flags, and a clean start/busy/done handshake.
- Runs one quotient bit per clock, then one sign-fix cycle. Sits beside the multiplier under the ALU control FSM.

---
 rtl/seq_divider_n.sv | 163 ++++++++++++++++
 tb/tb_seq_divider_n.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_n.sv
`default_nettype none
// ============================================================================
// seq_divider_n : restoring signed/unsigned divider, one quotient bit per
//                 clock plus a sign-fix cycle, with div-by-zero/overflow flags.
// Revision      : 1.0
// ============================================================================
module seq_divider_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] c_min_val   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);

    state_t             state_q,     state_d;
    logic [WIDTH-1:0]   a_q,         a_d;
    logic [WIDTH-1:0]   q_q,         q_d;
    logic [WIDTH-1:0]   m_q,         m_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               neg_quo_q,   neg_quo_d;
    logic               neg_rem_q,   neg_rem_d;
    logic               ovf_pend_q,  ovf_pend_d;
    logic [WIDTH-1:0]   quotient_q,  quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               dbz_q,       dbz_d;
    logic               ovf_q,       ovf_d;

    logic               accept;
    logic [WIDTH-1:0]   dvd_mag;
    logic [WIDTH-1:0]   dvs_mag;
    logic [WIDTH:0]     a_shift;
    logic [WIDTH:0]     trial;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            q_q         <= '0;
            m_q         <= '0;
            cnt_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            ovf_pend_q  <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            q_q         <= q_d;
            m_q         <= m_d;
            cnt_q       <= cnt_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            ovf_pend_q  <= ovf_pend_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        q_d         = q_q;
        m_d         = m_q;
        cnt_d       = cnt_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        ovf_pend_d  = ovf_pend_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        accept  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
        dvd_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
        dvs_mag = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

        // Partial remainder never exceeds the divisor, so WIDTH+1 bits hold
        // both the shifted value and the signed trial difference.
        a_shift = {a_q, q_q[WIDTH-1]};
        trial   = a_shift - {1'b0, m_q};

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    neg_quo_d  = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_rem_d  = is_signed & dividend[WIDTH-1];
                    ovf_pend_d = is_signed && (dividend == c_min_val) && (divisor == '1);
                    m_d        = dvs_mag;
                    q_d        = dvd_mag;
                    a_d        = '0;
                    cnt_d      = '0;
                    ovf_d      = 1'b0;
                    if (divisor == '0) begin
                        // Divide-by-zero bypasses the iteration entirely
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        dbz_d   = 1'b0;
                        state_d = S_ITER;
                    end
                end
            end

            S_ITER: begin
                a_d   = trial[WIDTH] ? a_shift[WIDTH-1:0] : trial[WIDTH-1:0];
                q_d   = {q_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == c_last_iter) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                // MIN / -1 keeps its natural wrapped result; only the flag marks it
                quotient_d  = neg_quo_q ? -q_q : q_q;
                remainder_d = neg_rem_q ? -a_q : a_q;
                ovf_d       = ovf_pend_q;
                state_d     = S_DONE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = (state_q == S_ITER) || (state_q == S_FIX);
    assign done        = (state_q == S_DONE);
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider_n.sv
`default_nettype none
// ============================================================================
// tb_seq_divider_n : directed-vector bench for seq_divider_n (WIDTH 8 and 16).
// Revision         : 1.0
// ============================================================================
module tb_seq_divider_n;

    logic        clk;
    logic        rst;

    logic        s8_start, s8_signed;
    logic [7:0]  s8_dividend, s8_divisor, s8_quotient, s8_remainder;
    logic        s8_busy, s8_done, s8_dbz, s8_ovf;

    logic        s16_start, s16_signed;
    logic [15:0] s16_dividend, s16_divisor, s16_quotient, s16_remainder;
    logic        s16_busy, s16_done, s16_dbz, s16_ovf;

    int n_vec;
    int n_err;

    seq_divider_n #(.WIDTH(8)) u_dut8 (
        .clk         (clk),
        .rst         (rst),
        .start       (s8_start),
        .is_signed   (s8_signed),
        .dividend    (s8_dividend),
        .divisor     (s8_divisor),
        .quotient    (s8_quotient),
        .remainder   (s8_remainder),
        .busy        (s8_busy),
        .done        (s8_done),
        .div_by_zero (s8_dbz),
        .overflow    (s8_ovf)
    );

    seq_divider_n #(.WIDTH(16)) u_dut16 (
        .clk         (clk),
        .rst         (rst),
        .start       (s16_start),
        .is_signed   (s16_signed),
        .dividend    (s16_dividend),
        .divisor     (s16_divisor),
        .quotient    (s16_quotient),
        .remainder   (s16_remainder),
        .busy        (s16_busy),
        .done        (s16_done),
        .div_by_zero (s16_dbz),
        .overflow    (s16_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One 8-bit operation; optionally pulses a second start at cycle 'poke'.
    task automatic run8(input string tag, input logic sg, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input logic edz, input logic eov,
                        input int edone, input int poke);
        int  cyc;
        int  nbusy;
        bit  got;
        @(negedge clk);
        s8_start    = 1'b1;
        s8_signed   = sg;
        s8_dividend = a;
        s8_divisor  = b;
        @(negedge clk);
        s8_start = 1'b0;
        cyc   = 1;
        nbusy = 0;
        got   = 1'b0;
        while (!got && cyc <= 40) begin
            if (s8_done) begin
                got = 1'b1;
            end else begin
                if (s8_busy) nbusy++;
                if (cyc == poke) begin
                    s8_start    = 1'b1;
                    s8_dividend = 8'd9;
                    s8_divisor  = 8'd2;
                end else begin
                    s8_start = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        s8_start = 1'b0;
        check_eq({tag, ".done_cycle"}, got ? 32'(cyc) : 32'hFFFF_FFFF, 32'(edone));
        check_eq({tag, ".busy_cycles"}, 32'(nbusy), 32'(edone - 1));
        check_eq({tag, ".quotient"}, {24'd0, s8_quotient}, {24'd0, eq});
        check_eq({tag, ".remainder"}, {24'd0, s8_remainder}, {24'd0, er});
        check_eq({tag, ".div_by_zero"}, {31'd0, s8_dbz}, {31'd0, edz});
        check_eq({tag, ".overflow"}, {31'd0, s8_ovf}, {31'd0, eov});
        @(negedge clk);
        check_eq({tag, ".done_pulse_end"}, {31'd0, s8_done}, 32'd0);
    endtask

    initial begin
        int cyc;
        int ndone;
        int last;

        n_vec = 0;
        n_err = 0;
        rst          = 1'b0;
        s8_start     = 1'b0;
        s8_signed    = 1'b0;
        s8_dividend  = '0;
        s8_divisor   = '0;
        s16_start    = 1'b0;
        s16_signed   = 1'b0;
        s16_dividend = '0;
        s16_divisor  = '0;

        repeat (2) @(negedge clk);
        check_eq("reset.outputs8", {s8_quotient, s8_remainder, 12'd0, s8_busy, s8_done, s8_dbz, s8_ovf}, 32'd0);
        check_eq("reset.outputs16", {s16_quotient, s16_remainder}, 32'd0);
        check_eq("reset.flags16", {28'd0, s16_busy, s16_done, s16_dbz, s16_ovf}, 32'd0);
        rst = 1'b1;

        run8("u100_7",    1'b0, 8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 10, -1);
        run8("s-100_7",   1'b1, 8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0, 10, -1);
        run8("s100_-7",   1'b1, 8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0, 10, -1);
        run8("s-100_-7",  1'b1, 8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0, 10, -1);
        run8("dbz",       1'b0, 8'h2A, 8'h00, 8'hFF, 8'h2A, 1'b1, 1'b0, 1,  -1);
        run8("after_dbz", 1'b0, 8'h2A, 8'h06, 8'h07, 8'h00, 1'b0, 1'b0, 10, -1);
        run8("s_ovf",     1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, 10, -1);
        run8("u_80_ff",   1'b0, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 1'b0, 10, -1);
        run8("ign_start", 1'b0, 8'd200, 8'd3, 8'h42, 8'h02, 1'b0, 1'b0, 10, 4);

        // Reset in cycle 5 of an operation: outputs drop at once, no done follows
        @(negedge clk);
        s8_start    = 1'b1;
        s8_signed   = 1'b0;
        s8_dividend = 8'd200;
        s8_divisor  = 8'd3;
        @(negedge clk);
        s8_start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("midrst.q_r", {16'd0, s8_quotient, s8_remainder}, 32'd0);
        check_eq("midrst.flags", {28'd0, s8_busy, s8_done, s8_dbz, s8_ovf}, 32'd0);
        @(negedge clk);
        rst   = 1'b1;
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (s8_done) ndone++;
        end
        check_eq("midrst.no_done", 32'(ndone), 32'd0);

        run8("post_rst", 1'b0, 8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 10, -1);

        // WIDTH=16 with start held high: done every 18 cycles
        @(negedge clk);
        s16_signed   = 1'b0;
        s16_dividend = 16'hFFFF;
        s16_divisor  = 16'h0003;
        s16_start    = 1'b1;
        cyc   = 0;
        ndone = 0;
        last  = 0;
        while (ndone < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (s16_done) begin
                ndone++;
                check_eq("w16.done_gap", 32'(cyc - last), 32'd18);
                check_eq("w16.quotient", {16'd0, s16_quotient}, 32'h5555);
                check_eq("w16.remainder", {16'd0, s16_remainder}, 32'h0);
                last = cyc;
            end
        end
        s16_start = 1'b0;
        check_eq("w16.done_count", 32'(ndone), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
